// File: rtl/mod_bfly_r2_if.sv
// Butterfly operand/result bundle for mod_bfly_r2.
// Master drives operands and modulus, slave returns the butterfly pair.
interface mod_bfly_r2_if #(
    parameter int P_WIDTH = 64
);
    logic               valid_in;
    logic [P_WIDTH-1:0] X_in;
    logic [P_WIDTH-1:0] M_in;
    logic [P_WIDTH-1:0] N_in;
    logic [P_WIDTH-1:0] S0_out;
    logic [P_WIDTH-1:0] S1_out;
    logic               valid_out;

    modport master (
        output valid_in, X_in, M_in, N_in,
        input  S0_out, S1_out, valid_out
    );

    modport slave (
        input  valid_in, X_in, M_in, N_in,
        output S0_out, S1_out, valid_out
    );
endinterface

// File: rtl/mod_bfly_r2.sv
// Radix-2 modular butterfly behind MulMod128: (X+M) mod N, (X-M) mod N.
// X is delayed to meet the multiplier result, then two register stages.
module mod_bfly_r2 #(
    parameter int P_WIDTH = 64,
    parameter int MUL_LAT = 4
) (
    input logic           clk,
    input logic           rst_n,
    mod_bfly_r2_if.slave  bus
);

    logic [P_WIDTH-1:0] dl_x [MUL_LAT];
    logic [MUL_LAT-1:0] dl_v;

    logic [P_WIDTH:0]   sum1;
    logic [P_WIDTH:0]   dif1;
    logic [P_WIDTH-1:0] n1;
    logic               v1;

    logic [P_WIDTH-1:0] s0_q;
    logic [P_WIDTH-1:0] s1_q;
    logic               v2;

    logic [P_WIDTH-1:0] xd;
    logic               vd;
    logic [P_WIDTH-1:0] t;
    logic               ge;
    logic [P_WIDTH-1:0] s0_nxt;
    logic [P_WIDTH-1:0] s1_nxt;

    assign xd = dl_x[MUL_LAT-1];
    assign vd = dl_v[MUL_LAT-1];

    // Delay line: carry {valid, X} forward until the multiplier result lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                dl_x[i] <= '0;
            end
            dl_v <= '0;
        end else begin
            dl_x[0] <= bus.X_in;
            dl_v[0] <= bus.valid_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                dl_x[i] <= dl_x[i-1];
                dl_v[i] <= dl_v[i-1];
            end
        end
    end

    // Stage 1: wide sum and difference (bit P_WIDTH of the difference is the borrow)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum1 <= '0;
            dif1 <= '0;
            n1   <= '0;
            v1   <= 1'b0;
        end else begin
            sum1 <= {1'b0, xd} + {1'b0, bus.M_in};
            dif1 <= {1'b0, xd} - {1'b0, bus.M_in};
            n1   <= bus.N_in;
            v1   <= vd;
        end
    end

    // Final correction: subtract N from the sum if it reached N, add N back on borrow
    always_comb begin
        t      = sum1[P_WIDTH-1:0] - n1;
        ge     = (sum1 >= {1'b0, n1});
        s0_nxt = ge ? t : sum1[P_WIDTH-1:0];
        s1_nxt = dif1[P_WIDTH] ? (dif1[P_WIDTH-1:0] + n1)
                               : dif1[P_WIDTH-1:0];
    end

    // Stage 2: register the reduced butterfly outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
            v2   <= 1'b0;
        end else begin
            s0_q <= s0_nxt;
            s1_q <= s1_nxt;
            v2   <= v1;
        end
    end

    assign bus.S0_out    = s0_q;
    assign bus.S1_out    = s1_q;
    assign bus.valid_out = v2;

endmodule

// File: doc/mod_bfly_r2.md
Name: mod_bfly_r2

Overview:
- Radix-2 modular butterfly stage placed directly downstream of MulMod128 in the R16 NTT datapath.
- Consumes the twiddled operand M_in (MulMod128 S_out) and the un-multiplied operand X_in.
- Produces (X+M) mod N and (X-M) mod N, fully pipelined at one butterfly per clock.
- An internal delay line aligns X_in, which is presented in the same cycle as the MulMod128 A_in/B_in, with the multiplier result.

Parameters:
- P_WIDTH, 64, data/modulus width.
- MUL_LAT, 4, cycles from MulMod128 input sample to valid S_out; sets delay-line depth (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  X_in (and the multiplier operands) valid this cycle.
- X_in  input  P_WIDTH  un-multiplied butterfly operand, value in [0,N).
- M_in  input  P_WIDTH  MulMod128 S_out, value in [0,N); sampled MUL_LAT cycles after the matching valid_in.
- N_in  input  P_WIDTH  modulus; quasi-static (changes only when pipeline empty).
- S0_out  output  P_WIDTH  (X+M) mod N, registered.
- S1_out  output  P_WIDTH  (X-M) mod N, registered.
- valid_out  output  1  S0_out/S1_out valid.

Behaviour:
- Reset (rst_n=0, async): delay-line data/valid, stage regs, S0_out, S1_out, valid_out all forced to 0 immediately. No clk needed.
- Delay line: MUL_LAT-deep shift register of {valid_in, X_in}, shifts every clk, no stall. Tap Xd/Vd aligns with M_in.
- Stage 1 (registered on clk):
  - sum65 = {0,Xd} + {0,M_in}.
  - dif65 = {0,Xd} - {0,M_in}; bit64 = borrow.
  - Register sum65, dif65, N_in copy (N1), Vd.
- Stage 2 (registered on clk):
  - t = sum65 - {0,N1} (65-bit). If sum65 >= N1 (no borrow in t), S0_out <= t[63:0]; else S0_out <= sum65[63:0].
  - If dif borrow, S1_out <= dif65[63:0] + N1 (mod 2^64); else S1_out <= dif65[63:0].
  - valid_out <= stage-1 valid.
- Latency: valid_in at edge k gives valid_out high after edge k+MUL_LAT+2. Throughput 1/cycle; back-to-back valids produce back-to-back outputs.
- Data regs update every cycle regardless of valid. Outputs when valid_out=0 are don't-care for checking, but must be 0 after reset until first valid reaches the output.
- Boundaries:
  - sum exactly N gives 0.
  - sum carry into bit 64 (X+M >= 2^64) must still reduce correctly via the 65-bit compare.
  - X==M gives S1=0.
  - X<M gives N-(M-X).
- Operands >= N: outside contract, result unspecified, no hang.
- Reset mid-stream: all in-flight data discarded. First valid_out after release requires a fresh valid_in plus full latency.
- N_in change with valids in flight: outside contract.

Test Plan:
- N=0xFFFFFFFF00000001, X=5, M=3 -> S0=0x8, S1=0x2, valid_out exactly MUL_LAT+2 cycles after valid_in.
- X=3, M=5 -> S0=0x8, S1=0xFFFFFFFEFFFFFFFF (N-2).
- X=N-1, M=1 -> S0=0x0 (sum==N), S1=0xFFFFFFFEFFFFFFFF; then X=N-1, M=N-1 -> S0=0xFFFFFFFEFFFFFFFF (2^64 carry path), S1=0x0.
- 16 consecutive valids, X=i, M=i+1 for i=0..15 -> 16 consecutive valid_out, S0=2i+1, S1=N-1 each, in order, no gaps.
- Stream of 8 valids, assert rst_n=0 asynchronously mid-cycle after 3 -> outputs and valid_out 0 immediately. After release with no valid_in, valid_out stays 0 for >= MUL_LAT+4 cycles.
- Random 10k pairs in [0,N) with valid toggling ~50%, compare against reference model (X+M)%N, (X-M+N)%N -> zero mismatches, valid count in == count out.
